// File: rtl/tile_reader_if.sv
// Avalon-MM pipelined read bus between the tile reader and SDRAM.
// The master drives address/read; the slave drives stall and responses.
interface tile_reader_if;
    logic [31:0] master_address;
    logic        master_read;
    logic        master_wait_request;
    logic [31:0] master_read_data;
    logic        master_read_data_valid;

    modport master (
        output master_address,
        output master_read,
        input  master_wait_request,
        input  master_read_data,
        input  master_read_data_valid
    );

    modport slave (
        input  master_address,
        input  master_read,
        output master_wait_request,
        output master_read_data,
        output master_read_data_valid
    );
endinterface

// File: rtl/tile_reader.sv
// Fetches one tile (WORDS_PER_ROW x ROWS bus words) from SDRAM into tile RAM
// through a pipelined read master with a bounded number of outstanding reads.
module tile_reader #(
    parameter int WORDS_PER_ROW = 16,
    parameter int ROWS          = 32,
    parameter int MAX_PENDING   = 8,
    localparam int AW = $clog2(WORDS_PER_ROW * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   addr_in,
    input  logic [15:0]   stride_in,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr_out,
    output logic [31:0]   ram_data,
    output logic          ram_wren,
    tile_reader_if.master bus
);
    localparam int WB = $clog2(WORDS_PER_ROW);
    localparam int RB = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   row_base;
    logic [15:0]   stride;
    logic [WB-1:0] word_idx;
    logic [RB-1:0] row_idx;
    logic [3:0]    pending;
    logic [AW-1:0] wr_ptr;

    logic accept;
    logic resp;
    logic last_issue;
    logic last_resp;

    // Reads only go out while the outstanding window has room; address and
    // request depend on registers alone so they hold steady under a stall.
    assign bus.master_read    = (state == ISSUE) && (pending < 4'(MAX_PENDING));
    assign bus.master_address = row_base + {{(30 - WB){1'b0}}, word_idx, 2'b00};

    assign busy       = (state != IDLE);
    assign accept     = bus.master_read && !bus.master_wait_request;
    assign resp       = bus.master_read_data_valid && (state != IDLE);
    assign last_issue = accept && (&word_idx) && (&row_idx);
    assign last_resp  = resp && (&wr_ptr);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: issue all reads, then wait for the final write.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)      state_next = ISSUE;
            ISSUE:   if (last_issue) state_next = DRAIN;
            DRAIN:   if (done)       state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Address walk, outstanding-read count and registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base     <= '0;
            stride       <= '0;
            word_idx     <= '0;
            row_idx      <= '0;
            pending      <= '0;
            wr_ptr       <= '0;
            ram_wren     <= 1'b0;
            ram_addr_out <= '0;
            ram_data     <= '0;
            done         <= 1'b0;
        end else begin
            ram_wren <= resp;
            done     <= last_resp;
            if (resp) begin
                ram_data     <= bus.master_read_data;
                ram_addr_out <= wr_ptr;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (state == IDLE && start) begin
                row_base <= addr_in;
                stride   <= stride_in;
                word_idx <= '0;
                row_idx  <= '0;
                pending  <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) begin
                    word_idx <= word_idx + WB'(1);
                    if (&word_idx) begin
                        row_base <= row_base + {16'b0, stride};
                        row_idx  <= row_idx + RB'(1);
                    end
                end
                if (accept && !resp) begin
                    pending <= pending + 4'd1;
                end else if (!accept && resp && pending != 4'd0) begin
                    pending <= pending - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tile_reader.sv
// Bench for tile_reader: randomized Avalon slave plus a tile-level model
// (address formula, response order, outstanding window) checked every cycle.
module tb_tile_reader;
    localparam int TOTAL = 512;
    localparam int MAXP  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr_in = '0;
    logic [15:0] stride_in = '0;
    logic        busy;
    logic        done;
    logic [8:0]  ram_addr_out;
    logic [31:0] ram_data;
    logic        ram_wren;

    tile_reader_if bus();

    tile_reader #(
        .WORDS_PER_ROW(16),
        .ROWS(32),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .addr_in(addr_in),
        .stride_in(stride_in),
        .busy(busy),
        .done(done),
        .ram_addr_out(ram_addr_out),
        .ram_data(ram_data),
        .ram_wren(ram_wren),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // model state
    logic        m_active = 1'b0;
    logic        m_wren = 1'b0;
    int          m_iss = 0;
    int          m_rcv = 0;
    int          m_pend = 0;
    int          m_wr_addr = 0;
    logic [31:0] m_base = '0;
    logic [15:0] m_stride = '0;

    // slave state
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          wait_pct = 0;
    int          lat_min = 2;
    int          lat_max = 2;
    int          stall_word = -1;
    int          stall_left = 0;
    int          stray_left = 0;

    // per-run statistics
    int          done_cnt = 0;
    int          wren_cnt = 0;
    int          max_pend = 0;
    int          same_cyc = 0;
    int          stall_cycles = 0;
    int          stall_bad = 0;
    logic [31:0] first_addr = '0;
    logic [31:0] addr16 = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] ram_img[TOTAL];
    logic [31:0] snap[TOTAL];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Word k of the tile lives at base + stride*row + 4*word.
    function automatic logic [31:0] eaddr(int k);
        return m_base + 32'(m_stride) * 32'(k / 16) + 32'(4 * (k % 16));
    endfunction

    // Slave memory contents: a fixed scramble of the address.
    function automatic logic [31:0] dat(logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Per-cycle compare, slave response generation and model update.
    always @(negedge clk) begin
        logic        exp_rd;
        logic        w;
        logic        v;
        logic        acc;
        logic        was_active;
        logic [31:0] d;
        cyc++;
        chk("busy", 32'(busy), 32'(m_active));
        chk("ram_wren", 32'(ram_wren), 32'(m_wren));
        chk("done", 32'(done), 32'(m_wren && m_wr_addr == TOTAL - 1));
        if (m_wren && ram_wren) begin
            chk("ram_addr", 32'(ram_addr_out), 32'(m_wr_addr));
            chk("ram_data", ram_data, dat(eaddr(m_wr_addr)));
        end
        if (ram_wren) begin
            ram_img[ram_addr_out] = ram_data;
            wren_cnt++;
        end
        if (done) done_cnt++;
        exp_rd = m_active && m_iss < TOTAL && m_pend < MAXP;
        chk("master_read", 32'(bus.master_read), 32'(exp_rd));
        if (bus.master_read && exp_rd)
            chk("master_address", bus.master_address, eaddr(m_iss));

        w = ($urandom_range(0, 99) < wait_pct);
        if (bus.master_read && m_active && m_iss == stall_word && stall_left > 0) begin
            w = 1'b1;
            stall_left--;
            stall_cycles++;
            if (bus.master_address !== 32'h0000_1014) stall_bad++;
        end
        v = 1'b0;
        d = $urandom;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            v = 1'b1;
            d = dat(q_addr.pop_front());
            void'(q_due.pop_front());
        end else if (stray_left > 0) begin
            v = 1'b1;
            stray_left--;
        end
        bus.master_wait_request    = w;
        bus.master_read_data_valid = v;
        bus.master_read_data       = d;
        acc = bus.master_read && !w;
        if (acc) begin
            q_addr.push_back(bus.master_address);
            q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end

        was_active = m_active;
        if (rst) begin
            m_active = 1'b0;
            m_wren   = 1'b0;
            m_pend   = 0;
        end else begin
            if (m_wren && m_wr_addr == TOTAL - 1) m_active = 1'b0;
            m_wren = 1'b0;
            if (was_active) begin
                if (acc) begin
                    if (m_iss == 0) first_addr = bus.master_address;
                    if (m_iss == 16) addr16 = bus.master_address;
                    if (m_iss == TOTAL - 1) last_addr = bus.master_address;
                    m_iss++;
                end
                if (acc && !v) m_pend++;
                else if (!acc && v) m_pend--;
                if (acc && v) same_cyc++;
                if (m_pend > max_pend) max_pend = m_pend;
                if (v) begin
                    m_wren    = 1'b1;
                    m_wr_addr = m_rcv;
                    m_rcv++;
                end
            end else if (start) begin
                m_active = 1'b1;
                m_base   = addr_in;
                m_stride = stride_in;
                m_iss    = 0;
                m_rcv    = 0;
                m_pend   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        done_cnt     = 0;
        wren_cnt     = 0;
        max_pend     = 0;
        same_cyc     = 0;
        stall_cycles = 0;
        stall_bad    = 0;
    endtask

    task automatic kick(logic [31:0] a, logic [15:0] s);
        addr_in   = a;
        stride_in = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        addr_in   = $urandom;
        stride_in = 16'($urandom);
    endtask

    task automatic wait_done(string nm, int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: done_count=0 want 1", nm);
        end
        tick();
        tick();
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int diffs;
        int w0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr_out), 32'd0);
        chk("rst_ram_data", ram_data, 32'd0);
        chk("rst_master_read", 32'(bus.master_read), 32'd0);
        chk("rst_master_address", bus.master_address, 32'd0);
        rst = 1'b0;
        tick();

        // zero wait states, 2-cycle latency
        clear_stats();
        wait_pct = 0; lat_min = 2; lat_max = 2;
        kick(32'h0000_1000, 16'd64);
        wait_done("run1", 5000);
        chk("run1_first", first_addr, 32'h0000_1000);
        chk("run1_addr16", addr16, 32'h0000_1040);
        chk("run1_last", last_addr, 32'h0000_17FC);
        chk("run1_wren_cnt", wren_cnt, 32'd512);
        chk("run1_done_cnt", done_cnt, 32'd1);
        chk("run1_same_cycle", same_cyc, 32'd510);
        chk("run1_max_pend", max_pend, 32'd2);
        for (int i = 0; i < TOTAL; i++) snap[i] = ram_img[i];

        // stall three cycles on word 5
        clear_stats();
        stall_word = 5; stall_left = 3;
        kick(32'h0000_1000, 16'd64);
        wait_done("run2", 5000);
        stall_word = -1;
        chk("run2_stall_cycles", stall_cycles, 32'd3);
        chk("run2_stall_addr_bad", stall_bad, 32'd0);
        chk("run2_wren_cnt", wren_cnt, 32'd512);
        diffs = 0;
        for (int i = 0; i < TOTAL; i++) if (ram_img[i] !== snap[i]) diffs++;
        chk("run2_ram_diffs", diffs, 32'd0);

        // long latency fills the outstanding window
        clear_stats();
        lat_min = 20; lat_max = 20;
        kick(32'h0004_0000, 16'h0800);
        wait_done("run3", 20000);
        chk("run3_max_pend", max_pend, 32'd8);
        chk("run3_wren_cnt", wren_cnt, 32'd512);
        chk("run3_done_cnt", done_cnt, 32'd1);

        // random stalls/latency, address wrap, start pulsed mid-fetch
        clear_stats();
        wait_pct = 30; lat_min = 1; lat_max = 6;
        kick(32'hFFFF_8000, 16'hFFFC);
        repeat (300) tick();
        addr_in = 32'hDEAD_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("run4", 20000);
        chk("run4_first", first_addr, 32'hFFFF_8000);
        chk("run4_last", last_addr, 32'hFFFF_8000 + 32'd31 * 32'h0000_FFFC + 32'h3C);
        chk("run4_wren_cnt", wren_cnt, 32'd512);
        chk("run4_done_cnt", done_cnt, 32'd1);

        // zero stride: every row reads the same 16 words
        clear_stats();
        wait_pct = 20; lat_min = 1; lat_max = 4;
        kick(32'h0000_3000, 16'd0);
        wait_done("run5", 20000);
        chk("run5_addr16", addr16, 32'h0000_3000);
        chk("run5_last", last_addr, 32'h0000_303C);
        chk("run5_wren_cnt", wren_cnt, 32'd512);

        // reset after 100 accepted reads, then stray responses
        clear_stats();
        wait_pct = 10; lat_min = 1; lat_max = 8;
        kick(32'h0010_0000, 16'h0100);
        n = 0;
        while (m_iss < 100 && n < 3000) begin
            tick();
            n++;
        end
        chk("run6_reached_100", 32'(m_iss >= 100), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w0 = wren_cnt;
        stray_left = 4;
        n = 0;
        while ((q_addr.size() > 0 || stray_left > 0) && n < 500) begin
            tick();
            n++;
        end
        chk("run6_strays_drained", 32'(q_addr.size() == 0 && stray_left == 0), 32'd1);
        repeat (5) tick();
        chk("run6_busy", 32'(busy), 32'd0);
        chk("run6_no_wren", wren_cnt, w0);
        chk("run6_no_done", done_cnt, 32'd0);

        // fresh fetch after the abandoned one
        clear_stats();
        wait_pct = 0; lat_min = 2; lat_max = 3;
        kick(32'h0000_2000, 16'd64);
        wait_done("run7", 5000);
        chk("run7_first", first_addr, 32'h0000_2000);
        chk("run7_last", last_addr, 32'h0000_27FC);
        chk("run7_wren_cnt", wren_cnt, 32'd512);
        chk("run7_done_cnt", done_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
